// File: rtl/i2s_receiver.sv
// i2s_receiver: slave I2S deserializer. Oversamples bck/ws/data in the clk
// domain and turns a 16-bit stereo stream into parallel left/right words.
// Latency: register updates land SYNC_STAGES+1 clk edges after bck is first
// sampled high. No backpressure: outputs are overwritten on every new word.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   audio_bck/ws/data        asynchronous serial inputs from the ADC/codec
//   audio_out_left/right     last complete word for each channel
//   sample_valid             1-clk pulse when a new left+right pair is shown
//   frame_err                1-clk pulse when a slot ends too early
//   locked                   high while aligned to word boundaries
module i2s_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  audio_bck,
  input  logic                  audio_ws,
  input  logic                  audio_data,
  output logic [DATA_WIDTH-1:0] audio_out_left,
  output logic [DATA_WIDTH-1:0] audio_out_right,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic                  locked
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic ST_UNLOCKED = 1'b0;
  localparam logic ST_LOCKED   = 1'b1;

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   bck_dly;

  logic                  state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  ws_prev;
  logic                  left_ok;
  logic [TW-1:0]         tcnt;

  logic                  bck_s;
  logic                  ws_s;
  logic                  data_s;
  logic                  rise;
  logic [DATA_WIDTH-1:0] word;

  assign bck_s  = bck_sync[SYNC_STAGES-1];
  assign ws_s   = ws_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign rise   = bck_s & ~bck_dly;
  assign locked = (state == ST_LOCKED);

  // A full-length slot ends with its LSB on the boundary bit; a padded slot
  // already holds the whole word and the boundary bit is padding.
  assign word = (cnt == CW'(DATA_WIDTH)) ? shift
                                          : {shift[DATA_WIDTH-2:0], data_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync  <= '0;
      ws_sync   <= '0;
      data_sync <= '0;
      bck_dly   <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], audio_bck};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], audio_ws};
      data_sync <= {data_sync[SYNC_STAGES-2:0], audio_data};
      bck_dly   <= bck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_UNLOCKED;
      cnt             <= '0;
      shift           <= '0;
      ws_prev         <= 1'b0;
      left_ok         <= 1'b0;
      tcnt            <= '0;
      audio_out_left  <= '0;
      audio_out_right <= '0;
      sample_valid    <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        // A rise always wins over timeout expiry in the same cycle.
        tcnt    <= '0;
        ws_prev <= ws_s;
        if (state == ST_UNLOCKED) begin
          if (ws_s != ws_prev) begin
            state <= ST_LOCKED;
            cnt   <= '0;
            shift <= '0;
          end
        end else if (ws_s == ws_prev) begin
          // Bits beyond DATA_WIDTH are slot padding and are dropped.
          if (cnt < CW'(DATA_WIDTH)) begin
            shift <= {shift[DATA_WIDTH-2:0], data_s};
            cnt   <= cnt + CW'(1);
          end
        end else begin
          cnt   <= '0;
          shift <= '0;
          if (cnt >= CW'(DATA_WIDTH - 1)) begin
            if (!ws_prev) begin
              audio_out_left <= word;
              left_ok        <= 1'b1;
            end else begin
              audio_out_right <= word;
              sample_valid    <= left_ok;
              left_ok         <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            left_ok   <= 1'b0;
          end
        end
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        // bck has gone quiet: drop alignment but keep the last outputs.
        tcnt    <= TW'(TIMEOUT);
        state   <= ST_UNLOCKED;
        left_ok <= 1'b0;
        cnt     <= '0;
        shift   <= '0;
      end else if (tcnt != TW'(TIMEOUT)) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Slave I2S receiver: deserializes a 16-bit stereo stream (bit clock, word select, serial data) from an external ADC or codec into parallel left/right samples.
- Sits at the audio input edge. It is the receive-side counterpart of speaker_control and uses the same pin framing: ws low = left, ws high = right, MSB one bck after each ws transition.
- All serial inputs are treated as asynchronous to clk. They are synchronized and edge-detected; no logic runs on the bck domain.

Parameters:
- DATA_WIDTH, 16, bits per channel word captured (MSB-first).
- SYNC_STAGES, 2, flip-flop stages on each serial input (minimum 2).
- TIMEOUT, 1024, clk cycles without a bck rising edge before lock is dropped.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- audio_bck  input  1  serial bit clock from source. Requirement: high and low phases each ≥ SYNC_STAGES+1 clk cycles.
- audio_ws  input  1  word select (0 = left, 1 = right); changes on bck falling edge.
- audio_data  input  1  serial data; MSB first; changes on bck falling edge.
- audio_out_left  output  DATA_WIDTH  last complete left word.
- audio_out_right  output  DATA_WIDTH  last complete right word.
- sample_valid  output  1  one-clk pulse when a new left/right pair is presented.
- frame_err  output  1  one-clk pulse on a short slot.
- locked  output  1  receiver aligned to word boundaries.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high, and has priority over all other logic.
- Reset state:
  - All outputs 0, synchronizers 0.
  - bit counter 0, shift register 0, ws_prev 0, left_ok 0, timeout counter 0.
- Synchronization and latency:
  - Each input passes through SYNC_STAGES flops; bck is delayed one more flop for edge detection.
  - Rise event = bck_sync & ~bck_dly. ws and data are taken from their synchronized copies in the same cycle.
  - Latency: the register updates caused by a rise occur at clk edge SYNC_STAGES+1, counting the first clk edge that samples audio_bck high as edge 1.
- States:
  - UNLOCKED (reset): on each rise, ws_prev <= ws. A rise with ws != ws_prev goes to LOCKED with counter = 0, shift cleared, no word output.
  - LOCKED, rise with ws == ws_prev: if counter < DATA_WIDTH, shift <= {shift, data} and counter++. Otherwise (counter == DATA_WIDTH) the bit is ignored; this covers padded slots wider than DATA_WIDTH.
  - LOCKED, rise with ws != ws_prev (boundary): this bit is the LSB slot of the word for channel ws_prev.
    - counter == DATA_WIDTH-1: word = {shift, data}.
    - counter == DATA_WIDTH: word = shift; boundary bit discarded.
    - counter < DATA_WIDTH-1: short slot. frame_err pulses, the word is discarded, left_ok <= 0, outputs hold.
    - In all cases: counter <= 0, shift <= 0, ws_prev <= ws.
- Word delivery:
  - Left word (ws_prev = 0): loads audio_out_left, left_ok <= 1.
  - Right word (ws_prev = 1): loads audio_out_right. If left_ok, sample_valid pulses in the same cycle the outputs update; then left_ok <= 0.
  - A right word without a preceding left word updates audio_out_right with no pulse.
- Timeout: the counter increments each clk and clears on each rise. Reaching TIMEOUT goes to UNLOCKED with locked = 0, left_ok = 0, partial word discarded. Outputs hold their last values.
- locked is 1 exactly in LOCKED.
- Reset mid-word: all state cleared. The first output after reset requires one boundary to lock, then a full left slot followed by a full right slot.
- Ws change coinciding with timeout expiry: the rise clears the timeout, so the boundary is processed normally.

Test Plan (bck = clk/8, 4 high / 4 low; 16 bck per slot unless stated):
- Reset, then 3 frames with left=16'hA55A, right=16'h1234 -> locked rises at the first ws edge. After the first full frame: out_left=A55A, out_right=1234, one sample_valid pulse per frame. Reset values are 0 before that.
- 32-bck slots carrying 16'hCAFE / 16'h0F0F followed by 16 padding ones -> outputs CAFE / 0F0F, no frame_err.
- Left slot with only 12 bits -> frame_err pulses once, out_left holds the prior value, no sample_valid for that frame, the next good frame is valid.
- Stop bck for 1100 clk -> locked falls; on restart, the first ws edge relocks and no sample_valid occurs until a full left+right pair.
- Assert rst for 1 clk in the middle of a right word -> outputs 0, locked 0, next sample_valid only after relock plus a full pair.
- Values 16'h8000 / 16'h7FFF -> exact outputs. The sample_valid pulse is exactly SYNC_STAGES+1 clk edges after the bck rise carrying the right LSB (checked against edge count).
